acc_bank: RTL

ACC_BANK -- requirements
Module: acc_bank

---
 rtl/acc_bank.sv | 136 +++++++++++++
 1 files changed

// File: rtl/acc_bank.sv
// acc_bank: per-channel row accumulator. Each channel builds a pass of rows in
// the uncommitted region of a circular buffer, optionally re-accumulating over
// several passes. The final pass commits its rows to a show-ahead read FIFO.
module acc_bank #(
  parameter int NUM_CH     = 4,
  parameter int LANES      = 4,
  parameter int P_BITWIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int SAT        = 0
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_CH-1:0]                        i_valid,
  output logic [NUM_CH-1:0]                        i_ready,
  input  logic [NUM_CH-1:0]                        i_first,
  input  logic [NUM_CH-1:0]                        i_last,
  input  logic [NUM_CH-1:0]                        i_store,
  input  logic [NUM_CH*LANES*P_BITWIDTH-1:0]       i_data,
  input  logic [NUM_CH-1:0]                        clear,
  output logic [NUM_CH-1:0]                        o_valid,
  input  logic [NUM_CH-1:0]                        o_ready,
  output logic [NUM_CH*LANES*P_BITWIDTH-1:0]       o_data,
  output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]      o_count,
  output logic [NUM_CH-1:0]                        empty,
  output logic [NUM_CH-1:0]                        full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = LANES * P_BITWIDTH;

  // One lane add; in saturating mode an overflow (operands share a sign that
  // the truncated sum does not) clamps to the extreme of the operands' sign.
  function automatic logic [P_BITWIDTH-1:0] laneAdd(input logic [P_BITWIDTH-1:0] a,
                                                    input logic [P_BITWIDTH-1:0] b);
    logic [P_BITWIDTH-1:0] s;
    s = a + b;
    if ((SAT != 0) && (a[P_BITWIDTH-1] == b[P_BITWIDTH-1]) &&
        (s[P_BITWIDTH-1] != a[P_BITWIDTH-1])) begin
      s = a[P_BITWIDTH-1] ? {1'b1, {(P_BITWIDTH-1){1'b0}}}
                          : {1'b0, {(P_BITWIDTH-1){1'b1}}};
    end
    return s;
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_base_q, wr_base_d;
    // row_cnt carries one extra bit so an over-long pass stalls instead of
    // wrapping onto committed rows.
    logic [CW-1:0] row_cnt_q, row_cnt_d;
    logic [CW-1:0] count_q, count_d;
    logic [RW-1:0] mem_q [DEPTH];
    logic [RW-1:0] in_row, old_row, new_row;
    logic [AW-1:0] tgt;
    logic          accept, rd_fire, commit;

    assign in_row  = i_data[c*RW +: RW];
    assign tgt     = wr_base_q + row_cnt_q[AW-1:0];
    assign old_row = mem_q[tgt];

    assign i_ready[c] = ({1'b0, count_q} + {1'b0, row_cnt_q}) < (CW+1)'(DEPTH);
    assign accept     = i_valid[c] & i_ready[c];
    assign o_valid[c] = (count_q != '0);
    assign rd_fire    = o_valid[c] & o_ready[c];
    assign commit     = accept & i_last[c] & i_store[c];

    assign o_data[c*RW +: RW]  = mem_q[rd_ptr_q];
    assign o_count[c*CW +: CW] = count_q;
    assign empty[c]            = (count_q == '0);
    assign full[c]             = (count_q == CW'(DEPTH));

    // Row value to write: the incoming beat on a first pass, else lane-wise sum.
    always_comb begin
      new_row = in_row;
      if (!i_first[c]) begin
        for (int l = 0; l < LANES; l++) begin
          new_row[l*P_BITWIDTH +: P_BITWIDTH] =
            laneAdd(old_row[l*P_BITWIDTH +: P_BITWIDTH], in_row[l*P_BITWIDTH +: P_BITWIDTH]);
        end
      end
    end

    // Pointer and count next-state; clear overrides both beat and read.
    always_comb begin
      rd_ptr_d  = rd_ptr_q;
      wr_base_d = wr_base_q;
      row_cnt_d = row_cnt_q;
      count_d   = count_q;
      if (clear[c]) begin
        rd_ptr_d  = '0;
        wr_base_d = '0;
        row_cnt_d = '0;
        count_d   = '0;
      end else begin
        if (rd_fire) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (accept) begin
          if (!i_last[c]) begin
            row_cnt_d = row_cnt_q + CW'(1);
          end else begin
            row_cnt_d = '0;
            if (i_store[c]) begin
              wr_base_d = wr_base_q + row_cnt_q[AW-1:0] + AW'(1);
            end
          end
        end
        count_d = count_q + (commit ? (row_cnt_q + CW'(1)) : CW'(0)) - CW'(rd_fire);
      end
    end

    // Channel control registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd_ptr_q  <= '0;
        wr_base_q <= '0;
        row_cnt_q <= '0;
        count_q   <= '0;
      end else begin
        rd_ptr_q  <= rd_ptr_d;
        wr_base_q <= wr_base_d;
        row_cnt_q <= row_cnt_d;
        count_q   <= count_d;
      end
    end

    // Row storage: single-cycle read-modify-write of the target row.
    always_ff @(posedge clk) begin
      if (accept && !clear[c]) begin
        mem_q[tgt] <= new_row;
      end
    end
  end

endmodule
